// File: rtl/dense7_pkg.sv
// Shared constants and FSM state type for the layer-7 dense MAC engine.
package dense7_pkg;

    localparam int NUM_IN   = 169;
    localparam int NUM_OUT  = 3;
    localparam int ADDR_W   = 10;
    localparam int X_ADDR_W = 8;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 24;

    localparam int OFFSET_ENT = 1;
    localparam int OFFSET_FIL = 0;
    localparam int OFFSET_SOR = -1;

    localparam logic [31:0] Q_MULT  = 32'd2014687024;
    localparam int          Q_SHIFT = 38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_QUANT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/dense7_requant.sv
// Combinational requantizer: acc * Q_MULT, round half up, arithmetic shift,
// output offset, then clamp to the signed DATA_W range.
module dense7_requant #(
    parameter int          ACC_W      = dense7_pkg::ACC_W,
    parameter int          DATA_W     = dense7_pkg::DATA_W,
    parameter logic [31:0] Q_MULT     = dense7_pkg::Q_MULT,
    parameter int          Q_SHIFT    = dense7_pkg::Q_SHIFT,
    parameter int          OFFSET_SOR = dense7_pkg::OFFSET_SOR
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] y_o
);

    // Wide enough for the full signed product plus the rounding constant.
    localparam int PW = ACC_W + 34;

    localparam logic signed [PW-1:0] RND   = PW'(64'd1 << (Q_SHIFT - 1));
    localparam logic signed [PW-1:0] Y_MAX = PW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] Y_MIN = PW'(-(1 << (DATA_W - 1)));

    logic signed [PW-1:0] acc_ext;
    logic signed [PW-1:0] mult_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic signed [PW-1:0] biased;

    // Rescale, offset and saturate the accumulator.
    always_comb begin
        acc_ext  = PW'(acc_i);
        mult_ext = PW'(Q_MULT);
        prod     = acc_ext * mult_ext;
        rounded  = prod + RND;
        shifted  = rounded >>> Q_SHIFT;
        biased   = shifted + PW'(OFFSET_SOR);
        if (biased > Y_MAX) begin
            y_o = Y_MAX[DATA_W-1:0];
        end else if (biased < Y_MIN) begin
            y_o = Y_MIN[DATA_W-1:0];
        end else begin
            y_o = biased[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/dense_7_mac.sv
// Fully-connected layer 7: walks NUM_IN inputs per output neuron, accumulates
// offset-corrected products, and streams one requantized result per neuron.
module dense_7_mac #(
    parameter int          NUM_IN     = dense7_pkg::NUM_IN,
    parameter int          NUM_OUT    = dense7_pkg::NUM_OUT,
    parameter int          ADDR_W     = dense7_pkg::ADDR_W,
    parameter int          X_ADDR_W   = dense7_pkg::X_ADDR_W,
    parameter int          DATA_W     = dense7_pkg::DATA_W,
    parameter int          ACC_W      = dense7_pkg::ACC_W,
    parameter int          OFFSET_ENT = dense7_pkg::OFFSET_ENT,
    parameter int          OFFSET_FIL = dense7_pkg::OFFSET_FIL,
    parameter int          OFFSET_SOR = dense7_pkg::OFFSET_SOR,
    parameter logic [31:0] Q_MULT     = dense7_pkg::Q_MULT,
    parameter int          Q_SHIFT    = dense7_pkg::Q_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                w_en,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    output logic                x_en,
    output logic [X_ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0]   x_data,
    output logic                y_valid,
    output logic [1:0]          y_index,
    output logic [DATA_W-1:0]   y_data
);

    import dense7_pkg::*;

    localparam int                  OP_W   = DATA_W + 1;
    localparam logic [X_ADDR_W-1:0] LAST_I = X_ADDR_W'(NUM_IN - 1);
    localparam logic [1:0]          LAST_O = 2'(NUM_OUT - 1);

    state_e                    state_q, state_d;
    logic [X_ADDR_W-1:0]       i_q, i_d;
    logic [1:0]                o_q, o_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         waddr_q, waddr_d;
    logic                      pv_q, pv_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      y_valid_q, y_valid_d;
    logic [1:0]                y_index_q, y_index_d;
    logic [DATA_W-1:0]         y_data_q, y_data_d;

    logic                      run_en;
    logic signed [OP_W-1:0]    w_op;
    logic signed [OP_W-1:0]    x_op;
    logic signed [2*OP_W-1:0]  prod;
    logic signed [DATA_W-1:0]  q_y;

    // Offset-corrected operands and their product for the returning data.
    always_comb begin
        w_op = $signed({w_data[DATA_W-1], w_data}) + OP_W'(OFFSET_FIL);
        x_op = $signed({x_data[DATA_W-1], x_data}) + OP_W'(OFFSET_ENT);
        prod = w_op * x_op;
    end

    dense7_requant #(
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .Q_MULT     (Q_MULT),
        .Q_SHIFT    (Q_SHIFT),
        .OFFSET_SOR (OFFSET_SOR)
    ) u_requant (
        .acc_i (acc_q),
        .y_o   (q_y)
    );

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        o_d       = o_q;
        acc_d     = acc_q;
        waddr_d   = waddr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        y_valid_d = 1'b0;
        y_index_d = y_index_q;
        y_data_d  = y_data_q;
        run_en    = 1'b0;

        // Data requested last cycle is on the bus now; fold it in.
        if (pv_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    i_d     = '0;
                    o_d     = '0;
                    acc_d   = '0;
                    waddr_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                run_en  = 1'b1;
                waddr_d = waddr_q + ADDR_W'(1);
                if (i_q == LAST_I) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + X_ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_QUANT;
            end
            ST_QUANT: begin
                y_valid_d = 1'b1;
                y_index_d = o_q;
                y_data_d  = q_y;
                if (o_q != LAST_O) begin
                    o_d     = o_q + 2'd1;
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pv_d = run_en;
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            o_q       <= '0;
            acc_q     <= '0;
            waddr_q   <= '0;
            pv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_index_q <= '0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            o_q       <= o_d;
            acc_q     <= acc_d;
            waddr_q   <= waddr_d;
            pv_q      <= pv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            y_valid_q <= y_valid_d;
            y_index_q <= y_index_d;
            y_data_q  <= y_data_d;
        end
    end

    // Read enables follow the state directly so reset silences them at once.
    assign w_en    = (state_q == ST_RUN);
    assign x_en    = (state_q == ST_RUN);
    assign w_addr  = waddr_q;
    assign x_addr  = i_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign y_valid = y_valid_q;
    assign y_index = y_index_q;
    assign y_data  = y_data_q;

endmodule

// File: tb/tb_dense_7_mac.sv
// Bench for dense_7_mac: four instances with different requant settings share
// the same directed ROM/feature contents and are checked every cycle against
// a plain-arithmetic model of the layer.
module tb_dense_7_mac;

    localparam int NI  = 169;
    localparam int NO  = 3;
    localparam int ND  = 4;
    localparam int PER = NI + 2;

    localparam logic [31:0] P_MULT  [ND] = '{32'd2014687024, 32'd2, 32'd1, 32'd2};
    localparam int          P_SHIFT [ND] = '{38, 1, 2, 1};
    localparam int          P_FIL   [ND] = '{0, 0, 1, -1};
    localparam int          P_ENT        = 1;
    localparam int          P_SOR        = -1;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic       busy    [ND];
    logic       done    [ND];
    logic       w_en    [ND];
    logic       x_en    [ND];
    logic       y_valid [ND];
    logic [9:0] w_addr  [ND];
    logic [7:0] x_addr  [ND];
    logic [1:0] y_index [ND];
    logic [7:0] y_data  [ND];

    logic [7:0] wmem [NI*NO];
    logic [7:0] xmem [NI];

    int cyc    = 0;
    int t0     = 1 << 30;
    int errors = 0;
    int checks = 0;
    int expy   [ND][NO];
    int last_y [ND];
    int hits   [NI*NO];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [7:0] wd;
        logic [7:0] xd;

        always @(posedge clk) begin
            if (w_en[g]) wd <= wmem[w_addr[g]];
            if (x_en[g]) xd <= xmem[x_addr[g]];
        end

        dense_7_mac #(
            .Q_MULT     (P_MULT[g]),
            .Q_SHIFT    (P_SHIFT[g]),
            .OFFSET_FIL (P_FIL[g])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .busy    (busy[g]),
            .done    (done[g]),
            .w_en    (w_en[g]),
            .w_addr  (w_addr[g]),
            .w_data  (wd),
            .x_en    (x_en[g]),
            .x_addr  (x_addr[g]),
            .x_data  (xd),
            .y_valid (y_valid[g]),
            .y_index (y_index[g]),
            .y_data  (y_data[g])
        );
    end

    task automatic chk(input string nm, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d, rel %0d)",
                     nm, k, act, exp, cyc, cyc - t0);
        end
    endtask

    // Dot product of one weight row with the features, offsets applied.
    function automatic longint model_acc(input int k, input int o);
        longint acc;
        acc = 0;
        for (int i = 0; i < NI; i++) begin
            acc += longint'(($signed(wmem[o*NI + i]) + P_FIL[k]) * ($signed(xmem[i]) + P_ENT));
        end
        return acc;
    endfunction

    function automatic int model_y(input int k, input int o);
        longint r;
        r = (model_acc(k, o) * longint'(P_MULT[k]) + (longint'(1) <<< (P_SHIFT[k] - 1))) >>> P_SHIFT[k];
        r = r + P_SOR;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic load(input int sc);
        for (int j = 0; j < NI*NO; j++) begin
            case (sc)
                2:       wmem[j] = (j % NI == 0) ? 8'(j / NI + 1) : 8'h00;
                3:       wmem[j] = 8'h80;
                4:       wmem[j] = 8'h7F;
                5:       wmem[j] = (j == 0) ? 8'd5 : 8'h00;
                6:       wmem[j] = (j == 0) ? 8'hF9 : 8'h00;
                7:       wmem[j] = 8'(((j*37 + 11) % 17) - 8);
                default: wmem[j] = 8'h00;
            endcase
        end
        for (int i = 0; i < NI; i++) begin
            case (sc)
                2:       xmem[i] = (i == 0) ? 8'd9 : 8'hFF;
                3, 4:    xmem[i] = 8'h7F;
                5, 6:    xmem[i] = (i == 0) ? 8'h00 : 8'hFF;
                7:       xmem[i] = 8'(((i*53 + 7) % 29) - 14);
                default: xmem[i] = 8'hFF;
            endcase
        end
        for (int k = 0; k < ND; k++)
            for (int o = 0; o < NO; o++)
                expy[k][o] = model_y(k, o);
    endtask

    task automatic cover_check();
        int bad;
        bad = 0;
        for (int j = 0; j < NI*NO; j++) if (hits[j] != 1) bad++;
        chk("waddr_cover_bad", 0, bad, 0);
    endtask

    task automatic do_run(input bit extra50, input bit back2back);
        @(negedge clk); #2;
        start = 1'b1;
        t0 = cyc + 1;
        for (int j = 0; j < NI*NO; j++) hits[j] = 0;
        @(negedge clk); #2;
        start = 1'b0;
        if (extra50) begin
            while (cyc < t0 + 49) @(negedge clk);
            #2 start = 1'b1;
            @(negedge clk); #2;
            start = 1'b0;
        end
        while (cyc < t0 + 3*PER) @(negedge clk);
        #1 cover_check();
        if (back2back) begin
            #1 start = 1'b1;
            @(negedge clk); #2;
            t0 = cyc + 1;
            for (int j = 0; j < NI*NO; j++) hits[j] = 0;
            @(negedge clk); #2;
            start = 1'b0;
            while (cyc < t0 + 3*PER) @(negedge clk);
            #1 cover_check();
        end
        while (cyc < t0 + 3*PER + 3) @(negedge clk);
    endtask

    task automatic zero_check(input string tag);
        for (int k = 0; k < ND; k++) begin
            chk({tag, "_busy"}, k, busy[k], 0);
            chk({tag, "_done"}, k, done[k], 0);
            chk({tag, "_w_en"}, k, w_en[k], 0);
            chk({tag, "_x_en"}, k, x_en[k], 0);
            chk({tag, "_y_valid"}, k, y_valid[k], 0);
            chk({tag, "_w_addr"}, k, w_addr[k], 0);
            chk({tag, "_x_addr"}, k, x_addr[k], 0);
            chk({tag, "_y_index"}, k, y_index[k], 0);
            chk({tag, "_y_data"}, k, y_data[k], 0);
        end
    endtask

    task automatic do_reset_run();
        @(negedge clk); #2;
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk); #2;
        start = 1'b0;
        while (cyc < t0 + 99) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        t0 = 1 << 30;
        #1 zero_check("midrst");
        for (int k = 0; k < ND; k++) last_y[k] = 0;
        @(negedge clk); #2;
        rst = 1'b0;
        do_run(1'b0, 1'b0);
    endtask

    // Per-cycle comparison of every instance against the timing/value model.
    always @(negedge clk) begin : cmp
        int  rel;
        int  ob;
        int  ph;
        bit  run_e;
        bit  yv_e;
        rel   = cyc - t0;
        ob    = (rel >= 0) ? rel / PER : 0;
        ph    = (rel >= 0) ? rel % PER : 0;
        run_e = (rel >= 0) && (rel < 3*PER) && (ph <= NI - 1);
        yv_e  = (rel >= PER) && (rel <= 3*PER) && (ph == 0);
        if (w_en[0] && (w_addr[0] < 10'(NI*NO))) hits[w_addr[0]]++;
        for (int k = 0; k < ND; k++) begin
            chk("busy", k, busy[k], (rel >= 0) && (rel <= 3*PER));
            chk("done", k, done[k], rel == 3*PER + 1);
            chk("y_valid", k, y_valid[k], yv_e);
            chk("w_en", k, w_en[k], run_e);
            chk("x_en", k, x_en[k], run_e);
            if (run_e) begin
                chk("w_addr", k, w_addr[k], ob*NI + ph);
                chk("x_addr", k, x_addr[k], ph);
            end
            if (yv_e) begin
                chk("y_index", k, y_index[k], ob - 1);
                last_y[k] = expy[k][ob - 1];
            end
            chk("y_data", k, int'($signed(y_data[k])), last_y[k]);
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < ND; k++) last_y[k] = 0;
        load(1);
        repeat (3) @(negedge clk);
        #1 zero_check("rst");
        #1 rst = 1'b0;

        // All-zero weights, x=-1: accumulator 0, result is the output offset.
        for (int o = 0; o < NO; o++) chk("model_s1_q2", o, expy[1][o], -1);
        chk("model_s1_def", 0, expy[0][0], -1);
        do_run(1'b1, 1'b1);

        // One effective weight per row with a negative filter offset.
        load(2);
        chk("model_s2_o0", 3, expy[3][0], -1);
        chk("model_s2_o1", 3, expy[3][1], 9);
        chk("model_s2_o2", 3, expy[3][2], 19);
        do_run(1'b0, 1'b0);

        // Negative and positive saturation.
        load(3);
        chk("model_s3_acc", 1, model_acc(1, 0), -2768896);
        chk("model_s3_y", 1, expy[1][0], -128);
        do_run(1'b0, 1'b0);
        load(4);
        chk("model_s4_y", 1, expy[1][0], 127);
        do_run(1'b0, 1'b0);

        // Round half up in both signs.
        load(5);
        chk("model_s5_acc", 2, model_acc(2, 0), 6);
        chk("model_s5_y", 2, expy[2][0], 1);
        do_run(1'b0, 1'b0);
        load(6);
        chk("model_s6_acc", 2, model_acc(2, 0), -6);
        chk("model_s6_y", 2, expy[2][0], -2);
        do_run(1'b0, 1'b0);

        // Mixed small values, then an asynchronous reset mid-run and a clean rerun.
        load(7);
        do_run(1'b0, 1'b0);
        do_reset_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
